nios_dbg_ocimem_ctrl: RTL and testbench

Debug-monitor memory controller that consumes the system-clock-domain JTAG debug strobes (`take_action_ocimem_a`, `take_action_ocimem_b`, `take_no_action_ocimem_a`) and the `jdo` shift-register snapshot. It executes single-word reads and writes to the debug memory over an Avalon-MM master port. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the debug-slave TCK logic for scan-out. It sits directly downstream of the debug-slave sysclk stage, inside the CPU's OCI.

---
 rtl/nios_dbg_ocimem_pkg.sv | 19 +
 rtl/nios_dbg_ocimem_timeout.sv | 35 +++
 rtl/nios_dbg_ocimem_ctrl.sv | 157 +++++++++++++++
 tb/tb_nios_dbg_ocimem_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_dbg_ocimem_pkg.sv
// Shared state encoding and jdo field layout for the OCI debug-memory controller.
package nios_dbg_ocimem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_ERR  = 2'd3
    } ocimem_state_e;

    localparam int JDO_W     = 38;
    localparam int ADDR_LSB  = 26;
    localparam int RDNOW_BIT = 25;
    localparam int WDATA_MSB = 34;
    localparam int WDATA_LSB = 3;

    localparam logic [31:0] MONDREG_RST = 32'h0;

endpackage

// File: rtl/nios_dbg_ocimem_timeout.sv
// Wait-state counter for one Avalon access; tc_o fires in the stalled cycle
// that would bring the count to TIMEOUT, so the request can drop at that edge.
module nios_dbg_ocimem_timeout #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int CNT_W = 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = en_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/nios_dbg_ocimem_ctrl.sv
// OCI debug-monitor memory controller: one Avalon-MM word access per debug strobe.
// Requests assert the cycle after the strobe and hold through waitrequest, aborting after TIMEOUT stalls.
module nios_dbg_ocimem_ctrl
    import nios_dbg_ocimem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    ocimem_state_e     state_q, state_d;
    logic [ADDR_W-1:0] mona_q, mona_d;
    logic [31:0]       mondreg_q, mondreg_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic              ready_q;
    logic              any_strobe;
    logic              busy;
    logic              tmo_tc;
    logic              unused_jdo;

    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign busy       = (state_q == ST_RD) || (state_q == ST_WR);
    // Only the address, read-now and write-data fields are consumed.
    assign unused_jdo = ^jdo;

    nios_dbg_ocimem_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clr_i (state_q == ST_IDLE),
        .en_i  (busy && avm_waitrequest),
        .tc_o  (tmo_tc)
    );

    always_comb begin
        state_d   = state_q;
        mona_d    = mona_q;
        mondreg_d = mondreg_q;
        wdata_d   = wdata_q;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (take_action_ocimem_a) begin
                    mona_d = jdo[ADDR_LSB +: ADDR_W];
                    err_d  = 1'b0;
                    if (jdo[RDNOW_BIT]) begin
                        state_d = ST_RD;
                        rd_d    = 1'b1;
                    end
                end else if (take_action_ocimem_b) begin
                    mondreg_d = jdo[WDATA_MSB:WDATA_LSB];
                    wdata_d   = jdo[WDATA_MSB:WDATA_LSB];
                    state_d   = ST_WR;
                    wr_d      = 1'b1;
                end else if (take_no_action_ocimem_a) begin
                    state_d = ST_RD;
                    rd_d    = 1'b1;
                end
            end

            ST_RD: begin
                if (any_strobe) begin
                    err_d = 1'b1;
                end
                if (!avm_waitrequest) begin
                    mondreg_d = avm_readdata;
                    mona_d    = mona_q + ADDR_W'(1);
                    state_d   = ST_IDLE;
                end else if (tmo_tc) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    rd_d = 1'b1;
                end
            end

            ST_WR: begin
                if (any_strobe) begin
                    err_d = 1'b1;
                end
                if (!avm_waitrequest) begin
                    mona_d  = mona_q + ADDR_W'(1);
                    state_d = ST_IDLE;
                end else if (tmo_tc) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    wr_d = 1'b1;
                end
            end

            ST_ERR: begin
                if (any_strobe) begin
                    err_d = 1'b1;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mona_q    <= '0;
            mondreg_q <= MONDREG_RST;
            wdata_q   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            mona_q    <= mona_d;
            mondreg_q <= mondreg_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            ready_q   <= (state_d == ST_IDLE);
        end
    end

    assign avm_address   = mona_q;
    assign avm_read      = rd_q;
    assign avm_write     = wr_q;
    assign avm_writedata = wdata_q;
    assign MonDReg       = mondreg_q;
    assign monitor_ready = ready_q;
    assign monitor_error = err_q;

endmodule

// File: tb/tb_nios_dbg_ocimem_ctrl.sv
// Self-checking bench: directed scenarios plus randomized ops against a word-level model.
`timescale 1ns/1ps
module tb_nios_dbg_ocimem_ctrl;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [7:0]  avm_address;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata, avm_readdata;
    logic        avm_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic [7:0]  exp_addr;
    logic [31:0] exp_dreg;
    logic        exp_err;

    nios_dbg_ocimem_ctrl #(.ADDR_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .avm_address             (avm_address),
        .avm_read                (avm_read),
        .avm_write               (avm_write),
        .avm_writedata           (avm_writedata),
        .avm_readdata            (avm_readdata),
        .avm_waitrequest         (avm_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] jdo_a(input logic [7:0] addr, input bit rdnow);
        logic [37:0] j;
        j = {6'($urandom), 32'($urandom)};
        j[33:26] = addr;
        j[25] = rdnow;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] wd);
        logic [37:0] j;
        j = {6'($urandom), 32'($urandom)};
        j[34:3] = wd;
        return j;
    endfunction

    // Drive strobes for one cycle N; returns at N+1 (+1ns).
    task automatic strobe(input bit a, input bit b, input bit na, input logic [37:0] j);
        take_action_ocimem_a = a;
        take_action_ocimem_b = b;
        take_no_action_ocimem_a = na;
        jdo = j;
        cyc();
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        jdo = {6'($urandom), 32'($urandom)};
    endtask

    // Avalon slave: stalls 'waits' cycles then completes; optional strobe injected in request cycle inj_at.
    task automatic serve(input int waits, input int inj_at, output int rc, output logic [7:0] sa,
                         output logic [31:0] sd, output bit sw, output bit hung, output bit unst);
        int w;
        w = 0; rc = 0; sa = 'x; sd = 'x; sw = 1'b0; hung = 1'b1; unst = 1'b0;
        for (int i = 0; i < 4 * TIMEOUT; i++) begin
            if (!(avm_read || avm_write)) begin
                hung = 1'b0;
                break;
            end
            rc++;
            if (rc > 1 && (sa !== avm_address || sd !== avm_writedata || sw !== avm_write)) unst = 1'b1;
            sa = avm_address;
            sd = avm_writedata;
            sw = avm_write;
            if (w < waits) begin
                avm_waitrequest = 1'b1;
                avm_readdata = $urandom;
                w++;
            end else begin
                avm_waitrequest = 1'b0;
                avm_readdata = mem[avm_address];
                if (avm_write) mem[avm_address] = avm_writedata;
            end
            take_no_action_ocimem_a = (rc == inj_at);
            cyc();
            take_no_action_ocimem_a = 1'b0;
            avm_waitrequest = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cyc();
        checks++; if (avm_read !== 1'b0) begin errors++; $display("FAIL reset_read: got %b want 0", avm_read); end
        checks++; if (avm_write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b want 0", avm_write); end
        checks++; if (avm_writedata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", avm_writedata); end
        checks++; if (avm_address !== 8'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", avm_address); end
        checks++; if (MonDReg !== 32'h0) begin errors++; $display("FAIL reset_dreg: got %h want 0", MonDReg); end
        checks++; if (monitor_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", monitor_ready); end
        checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", monitor_error); end
        reset = 1'b0;
        cyc();
        exp_addr = 8'h0; exp_dreg = 32'h0; exp_err = 1'b0;
        checks++; if (monitor_ready !== 1'b1 || avm_read !== 1'b0) begin errors++; $display("FAIL post_reset_idle: ready=%b read=%b want 1/0", monitor_ready, avm_read); end
    endtask

    task automatic test_write_path();
        int rc; logic [7:0] sa; logic [31:0] sd; bit sw, hung, unst;
        strobe(1'b1, 1'b0, 1'b0, jdo_a(8'h10, 1'b0));
        exp_addr = 8'h10;
        checks++; if (avm_address !== 8'h10) begin errors++; $display("FAIL wp_addr_load: got %h want 10", avm_address); end
        checks++; if (monitor_ready !== 1'b1 || avm_read !== 1'b0) begin errors++; $display("FAIL wp_noread: ready=%b read=%b want 1/0", monitor_ready, avm_read); end
        strobe(1'b0, 1'b1, 1'b0, jdo_b(32'hCAFEF00D));
        checks++; if (avm_write !== 1'b1) begin errors++; $display("FAIL wp_write_n1: got %b want 1", avm_write); end
        checks++; if (avm_writedata !== 32'hCAFEF00D) begin errors++; $display("FAIL wp_wdata: got %h want cafef00d", avm_writedata); end
        checks++; if (monitor_ready !== 1'b0) begin errors++; $display("FAIL wp_busy: got %b want 0", monitor_ready); end
        checks++; if (MonDReg !== 32'hCAFEF00D) begin errors++; $display("FAIL wp_dreg: got %h want cafef00d", MonDReg); end
        serve(0, 0, rc, sa, sd, sw, hung, unst);
        ref_mem[8'h10] = 32'hCAFEF00D; exp_addr = 8'h11; exp_dreg = 32'hCAFEF00D;
        checks++; if (rc !== 1 || sa !== 8'h10) begin errors++; $display("FAIL wp_access: cycles=%0d addr=%h want 1/10", rc, sa); end
        checks++; if (monitor_ready !== 1'b1 || avm_write !== 1'b0) begin errors++; $display("FAIL wp_done_n2: ready=%b write=%b want 1/0", monitor_ready, avm_write); end
        checks++; if (avm_address !== 8'h11) begin errors++; $display("FAIL wp_incr: got %h want 11", avm_address); end
        checks++; if (mem[8'h10] !== 32'hCAFEF00D) begin errors++; $display("FAIL wp_mem: got %h want cafef00d", mem[8'h10]); end
    endtask

    task automatic test_readback();
        int rc; logic [7:0] sa; logic [31:0] sd; bit sw, hung, unst;
        strobe(1'b1, 1'b0, 1'b0, jdo_a(8'h10, 1'b1));
        checks++; if (avm_read !== 1'b1 || avm_address !== 8'h10) begin errors++; $display("FAIL rb_req: read=%b addr=%h want 1/10", avm_read, avm_address); end
        serve(3, 0, rc, sa, sd, sw, hung, unst);
        exp_addr = 8'h11; exp_dreg = 32'hCAFEF00D;
        checks++; if (rc !== 4 || hung) begin errors++; $display("FAIL rb_cycles: got %0d want 4", rc); end
        checks++; if (unst !== 1'b0) begin errors++; $display("FAIL rb_stable: got %b want 0", unst); end
        checks++; if (MonDReg !== 32'hCAFEF00D) begin errors++; $display("FAIL rb_dreg: got %h want cafef00d", MonDReg); end
        checks++; if (monitor_ready !== 1'b1 || avm_address !== 8'h11) begin errors++; $display("FAIL rb_done: ready=%b addr=%h want 1/11", monitor_ready, avm_address); end
    endtask

    task automatic test_wrap();
        int rc; logic [7:0] sa; logic [31:0] sd; bit sw, hung, unst;
        strobe(1'b1, 1'b0, 1'b0, jdo_a(8'hFF, 1'b0));
        strobe(1'b0, 1'b0, 1'b1, jdo_a(8'h33, 1'b1));
        serve(0, 0, rc, sa, sd, sw, hung, unst);
        checks++; if (sa !== 8'hFF || MonDReg !== ref_mem[8'hFF]) begin errors++; $display("FAIL wrap_rd_ff: addr=%h data=%h want ff/%h", sa, MonDReg, ref_mem[8'hFF]); end
        checks++; if (avm_address !== 8'h00) begin errors++; $display("FAIL wrap_addr: got %h want 00", avm_address); end
        strobe(1'b0, 1'b0, 1'b1, jdo_a(8'h44, 1'b1));
        serve(1, 0, rc, sa, sd, sw, hung, unst);
        checks++; if (sa !== 8'h00 || MonDReg !== ref_mem[8'h00]) begin errors++; $display("FAIL wrap_rd_00: addr=%h data=%h want 00/%h", sa, MonDReg, ref_mem[8'h00]); end
        exp_addr = 8'h01; exp_dreg = ref_mem[8'h00];
    endtask

    task automatic test_timeout();
        int rc; logic [7:0] sa; logic [31:0] sd; bit sw, hung, unst;
        strobe(1'b0, 1'b0, 1'b1, jdo_a(8'h55, 1'b1));
        serve(1000, 0, rc, sa, sd, sw, hung, unst);
        checks++; if (rc !== TIMEOUT || hung) begin errors++; $display("FAIL to_req_cycles: got %0d hung=%b want %0d", rc, hung, TIMEOUT); end
        checks++; if (monitor_error !== 1'b1 || monitor_ready !== 1'b0) begin errors++; $display("FAIL to_err_state: err=%b ready=%b want 1/0", monitor_error, monitor_ready); end
        checks++; if (MonDReg !== exp_dreg || avm_address !== exp_addr) begin errors++; $display("FAIL to_unchanged: dreg=%h addr=%h want %h/%h", MonDReg, avm_address, exp_dreg, exp_addr); end
        cyc();
        checks++; if (monitor_ready !== 1'b1 || monitor_error !== 1'b1) begin errors++; $display("FAIL to_ready: ready=%b err=%b want 1/1", monitor_ready, monitor_error); end
        strobe(1'b1, 1'b0, 1'b0, jdo_a(8'h40, 1'b0));
        exp_addr = 8'h40; exp_err = 1'b0;
        checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", monitor_error); end
    endtask

    task automatic test_overrun();
        int rc; logic [7:0] sa; logic [31:0] sd; bit sw, hung, unst;
        strobe(1'b0, 1'b0, 1'b1, jdo_a(8'h66, 1'b1));
        serve(5, 2, rc, sa, sd, sw, hung, unst);
        exp_dreg = ref_mem[8'h40]; exp_addr = 8'h41;
        checks++; if (rc !== 6) begin errors++; $display("FAIL ov_cycles: got %0d want 6", rc); end
        checks++; if (monitor_error !== 1'b1) begin errors++; $display("FAIL ov_err: got %b want 1", monitor_error); end
        checks++; if (MonDReg !== exp_dreg || avm_address !== exp_addr) begin errors++; $display("FAIL ov_complete: dreg=%h addr=%h want %h/%h", MonDReg, avm_address, exp_dreg, exp_addr); end
        cyc();
        checks++; if (avm_read !== 1'b0 || monitor_ready !== 1'b1) begin errors++; $display("FAIL ov_ignored: read=%b ready=%b want 0/1", avm_read, monitor_ready); end
        strobe(1'b0, 1'b1, 1'b0, jdo_b(32'h0BADBEEF));
        serve(0, 0, rc, sa, sd, sw, hung, unst);
        ref_mem[8'h41] = 32'h0BADBEEF; exp_dreg = 32'h0BADBEEF; exp_addr = 8'h42;
        checks++; if (monitor_error !== 1'b1) begin errors++; $display("FAIL ov_sticky: got %b want 1", monitor_error); end
        strobe(1'b1, 1'b0, 1'b0, jdo_a(8'h42, 1'b0));
        exp_err = 1'b0;
        checks++; if (monitor_error !== 1'b0) begin errors++; $display("FAIL ov_clear: got %b want 0", monitor_error); end
    endtask

    task automatic test_priority();
        int rc; logic [7:0] sa; logic [31:0] sd; bit sw, hung, unst;
        logic [31:0] wd_before;
        wd_before = avm_writedata;
        strobe(1'b1, 1'b1, 1'b0, jdo_a(8'h22, 1'b0));
        exp_addr = 8'h22;
        checks++; if (avm_write !== 1'b0 || avm_read !== 1'b0 || monitor_ready !== 1'b1) begin errors++; $display("FAIL pri_ab_noacc: wr=%b rd=%b ready=%b want 0/0/1", avm_write, avm_read, monitor_ready); end
        checks++; if (avm_address !== 8'h22 || MonDReg !== exp_dreg || avm_writedata !== wd_before) begin errors++; $display("FAIL pri_ab_load: addr=%h dreg=%h wd=%h want 22/%h/%h", avm_address, MonDReg, avm_writedata, exp_dreg, wd_before); end
        strobe(1'b0, 1'b1, 1'b1, jdo_b(32'h12345678));
        checks++; if (avm_write !== 1'b1 || avm_read !== 1'b0) begin errors++; $display("FAIL pri_bn: wr=%b rd=%b want 1/0", avm_write, avm_read); end
        serve(0, 0, rc, sa, sd, sw, hung, unst);
        ref_mem[8'h22] = 32'h12345678; exp_dreg = 32'h12345678; exp_addr = 8'h23;
        checks++; if (mem[8'h22] !== 32'h12345678 || avm_address !== 8'h23 || monitor_error !== 1'b0) begin errors++; $display("FAIL pri_bn_done: mem=%h addr=%h err=%b want 12345678/23/0", mem[8'h22], avm_address, monitor_error); end
    endtask

    task automatic test_random();
        int rc; logic [7:0] sa; logic [31:0] sd; bit sw, hung, unst;
        for (int n = 0; n < 40; n++) begin
            int kind, r, waits, exp_rc;
            logic [7:0] a8;
            logic [31:0] wd;
            bit rdn, acc, is_wr;
            kind = $urandom_range(0, 2);
            a8 = 8'($urandom);
            wd = $urandom;
            rdn = 1'($urandom);
            r = $urandom_range(0, 9);
            waits = (r == 0) ? TIMEOUT + 3 : (r == 1) ? TIMEOUT - 1 : $urandom_range(0, 4);
            acc = 1'b1; is_wr = 1'b0;
            if (kind == 0) begin
                strobe(1'b1, 1'b0, 1'b0, jdo_a(a8, rdn));
                exp_addr = a8; exp_err = 1'b0; acc = rdn;
            end else if (kind == 1) begin
                strobe(1'b0, 1'b1, 1'b0, jdo_b(wd));
                exp_dreg = wd; is_wr = 1'b1;
            end else begin
                strobe(1'b0, 1'b0, 1'b1, jdo_a(a8, rdn));
            end
            if (acc) begin
                serve(waits, 0, rc, sa, sd, sw, hung, unst);
                exp_rc = (waits < TIMEOUT) ? waits + 1 : TIMEOUT;
                checks++; if (rc !== exp_rc || hung) begin errors++; $display("FAIL rnd_cycles[%0d]: got %0d want %0d", n, rc, exp_rc); end
                checks++; if (sa !== exp_addr || sw !== is_wr || unst) begin errors++; $display("FAIL rnd_req[%0d]: addr=%h wr=%b unst=%b want %h/%b/0", n, sa, sw, unst, exp_addr, is_wr); end
                if (is_wr) begin
                    checks++; if (sd !== wd) begin errors++; $display("FAIL rnd_wdata[%0d]: got %h want %h", n, sd, wd); end
                end
                if (waits < TIMEOUT) begin
                    if (is_wr) ref_mem[exp_addr] = wd;
                    else exp_dreg = ref_mem[exp_addr];
                    exp_addr = exp_addr + 8'd1;
                end else begin
                    exp_err = 1'b1;
                    checks++; if (monitor_ready !== 1'b0) begin errors++; $display("FAIL rnd_errstate[%0d]: ready=%b want 0", n, monitor_ready); end
                    cyc();
                end
            end
            checks++; if (MonDReg !== exp_dreg) begin errors++; $display("FAIL rnd_dreg[%0d]: got %h want %h", n, MonDReg, exp_dreg); end
            checks++; if (avm_address !== exp_addr) begin errors++; $display("FAIL rnd_addr[%0d]: got %h want %h", n, avm_address, exp_addr); end
            checks++; if (monitor_error !== exp_err || monitor_ready !== 1'b1) begin errors++; $display("FAIL rnd_status[%0d]: err=%b ready=%b want %b/1", n, monitor_error, monitor_ready, exp_err); end
            repeat ($urandom_range(0, 2)) cyc();
        end
        for (int k = 0; k < 256; k++) begin
            if (mem[k] !== ref_mem[k]) begin
                checks++; errors++; $display("FAIL rnd_mem[%0d]: got %h want %h", k, mem[k], ref_mem[k]);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        strobe(1'b0, 1'b0, 1'b1, jdo_a(8'h77, 1'b1));
        avm_waitrequest = 1'b1;
        cyc();
        checks++; if (avm_read !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: read=%b want 1", avm_read); end
        #2 reset = 1'b1;
        #1;
        checks++; if (avm_read !== 1'b0) begin errors++; $display("FAIL rst_mid_read: got %b want 0", avm_read); end
        checks++; if (MonDReg !== 32'h0 || avm_address !== 8'h0 || avm_writedata !== 32'h0) begin errors++; $display("FAIL rst_mid_regs: dreg=%h addr=%h wd=%h want 0/0/0", MonDReg, avm_address, avm_writedata); end
        checks++; if (monitor_ready !== 1'b1 || monitor_error !== 1'b0 || avm_write !== 1'b0) begin errors++; $display("FAIL rst_mid_status: ready=%b err=%b wr=%b want 1/0/0", monitor_ready, monitor_error, avm_write); end
        cyc();
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        avm_readdata = 32'hDEADDEAD;
        repeat (2) cyc();
        exp_addr = 8'h0; exp_dreg = 32'h0; exp_err = 1'b0;
        checks++; if (avm_read !== 1'b0 || MonDReg !== 32'h0 || monitor_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_nocomplete: read=%b dreg=%h ready=%b want 0/0/1", avm_read, MonDReg, monitor_ready); end
    endtask

    initial begin
        reset = 1'b1;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        avm_readdata = '0;
        avm_waitrequest = 1'b0;
        for (int k = 0; k < 256; k++) begin
            mem[k] = $urandom;
            ref_mem[k] = mem[k];
        end
        test_reset();
        test_write_path();
        test_readback();
        test_wrap();
        test_timeout();
        test_overrun();
        test_priority();
        test_random();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
